// File: rtl/wb_port_if.sv
// Writeback bundle between the exec/dmem stages and the write-port scheduler.
// The master side produces results; the slave side (the scheduler) drives the write port.
interface wb_port_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            load_valid;
    logic [RA_W-1:0] load_rd;
    logic [XLEN-1:0] load_value;
    logic            exec_valid;
    logic [RA_W-1:0] exec_rd;
    logic [XLEN-1:0] exec_value;
    logic            stall_o;
    logic            rf_we;
    logic [RA_W-1:0] rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    modport master (
        output load_valid, load_rd, load_value, exec_valid, exec_rd, exec_value,
        input  stall_o, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  load_valid, load_rd, load_value, exec_valid, exec_rd, exec_value,
        output stall_o, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/wb_port_scheduler.sv
// Arbitrates the single register-file write port between load and exec results, retiring them
// in program order through a small FIFO. Optional buffer forwarding is enabled by WB_BUF_FWD_EN.
module wb_port_scheduler #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    wb_port_if.slave                     wb,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef WB_BUF_FWD_EN
    ,
    input  logic [RA_W-1:0]              fwd_rs,
    output logic                         fwd_hit,
    output logic [XLEN-1:0]              fwd_value
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] val;
    } entry_t;

    entry_t           buf_q [DEPTH];
    entry_t           buf_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             rf_we_q, rf_we_d;
    logic [RA_W-1:0]  rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;

    logic   stall;
    logic   load_acc, exec_acc;
    entry_t load_e, exec_e, cand, push0, push1;
    logic   cand_vld, push0_vld, push1_vld, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Stalling one entry early leaves room for a full pair even when the head cannot pop.
    assign stall    = (occ_q >= OCC_W'(DEPTH-1));
    assign load_acc = wb.load_valid & ~stall & (wb.load_rd != '0);
    assign exec_acc = wb.exec_valid & ~stall & (wb.exec_rd != '0);
    assign load_e   = '{rd: wb.load_rd, val: wb.load_value};
    assign exec_e   = '{rd: wb.exec_rd, val: wb.exec_value};

    always_comb begin
        cand      = '0;
        cand_vld  = 1'b0;
        push0     = '0;
        push0_vld = 1'b0;
        push1     = '0;
        push1_vld = 1'b0;
        pop       = 1'b0;
        if (occ_q != '0) begin
            cand     = buf_q[rd_ptr_q];
            cand_vld = 1'b1;
            pop      = 1'b1;
            if (load_acc) begin
                push0     = load_e;
                push0_vld = 1'b1;
                push1     = exec_e;
                push1_vld = exec_acc;
            end else begin
                push0     = exec_e;
                push0_vld = exec_acc;
            end
        end else if (load_acc) begin
            cand      = load_e;
            cand_vld  = 1'b1;
            push0     = exec_e;
            push0_vld = exec_acc;
        end else if (exec_acc) begin
            cand     = exec_e;
            cand_vld = 1'b1;
        end
    end

    always_comb begin
        buf_d = buf_q;
        if (push0_vld) buf_d[wr_ptr_q] = push0;
        if (push1_vld) buf_d[ptr_inc(wr_ptr_q)] = push1;
        wr_ptr_d   = push1_vld ? ptr_inc(ptr_inc(wr_ptr_q)) :
                     push0_vld ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        occ_d      = occ_q + OCC_W'(push0_vld) + OCC_W'(push1_vld) - OCC_W'(pop);
        rf_we_d    = cand_vld;
        rf_waddr_d = cand_vld ? cand.rd  : rf_waddr_q;
        rf_wdata_d = cand_vld ? cand.val : rf_wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            occ_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            occ_q      <= occ_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign wb.stall_o  = stall;
    assign wb.rf_we    = rf_we_q;
    assign wb.rf_waddr = rf_waddr_q;
    assign wb.rf_wdata = rf_wdata_q;
    assign occupancy   = occ_q;

`ifdef WB_BUF_FWD_EN
    // Scan oldest to youngest so the last match wins; the write-port register is the oldest.
    always_comb begin
        int idx;
        idx       = 0;
        fwd_hit   = 1'b0;
        fwd_value = '0;
        if (rf_we_q && rf_waddr_q == fwd_rs) begin
            fwd_hit   = 1'b1;
            fwd_value = rf_wdata_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = int'(rd_ptr_q) + i;
            if (idx >= DEPTH) idx = idx - DEPTH;
            if (i < int'(occ_q) && buf_q[idx[PTR_W-1:0]].rd == fwd_rs) begin
                fwd_hit   = 1'b1;
                fwd_value = buf_q[idx[PTR_W-1:0]].val;
            end
        end
        if (fwd_rs == '0) begin
            fwd_hit   = 1'b0;
            fwd_value = '0;
        end
    end
`endif
endmodule

// File: tb/tb_wb_port_scheduler.sv
// Randomized bench for wb_port_scheduler: a queue of accepted-but-unwritten results in program
// order predicts every write, the occupancy and the stall; forwarding is checked with WB_BUF_FWD_EN.
module tb_wb_port_scheduler;
    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int DEPTH = 4;
    localparam int OCC_W = $clog2(DEPTH+1);

    typedef struct {
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] val;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic [OCC_W-1:0] occupancy;
    always #5 clk = ~clk;

    wb_port_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

`ifdef WB_BUF_FWD_EN
    logic [RA_W-1:0] fwd_rs;
    logic            fwd_hit;
    logic [XLEN-1:0] fwd_value;
`endif

    wb_port_scheduler #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb        (bus),
        .occupancy (occupancy)
`ifdef WB_BUF_FWD_EN
        ,
        .fwd_rs    (fwd_rs),
        .fwd_hit   (fwd_hit),
        .fwd_value (fwd_value)
`endif
    );

    ent_t            q[$];
    logic            exp_we;
    logic [RA_W-1:0] exp_addr;
    logic [XLEN-1:0] exp_data;
    int              checks = 0;
    int              errors = 0;
    int              cyc    = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

`ifdef WB_BUF_FWD_EN
    task automatic fwd_probe(input logic [RA_W-1:0] rs);
        logic            hit;
        logic [XLEN-1:0] val;
        hit = 1'b0;
        val = '0;
        if (rs != '0) begin
            if (exp_we && exp_addr == rs) begin
                hit = 1'b1;
                val = exp_data;
            end
            foreach (q[k]) begin
                if (q[k].rd == rs) begin
                    hit = 1'b1;
                    val = q[k].val;
                end
            end
        end
        fwd_rs = rs;
        #1;
        check_eq("fwd_hit", 64'(fwd_hit), 64'(hit));
        if (hit) check_eq("fwd_value", 64'(fwd_value), 64'(val));
    endtask
`endif

    // Drive one cycle of inputs, advance the model, then compare the registered outputs.
    task automatic step(input logic r,
                        input logic lv, input logic [RA_W-1:0] lrd, input logic [XLEN-1:0] lval,
                        input logic ev, input logic [RA_W-1:0] erd, input logic [XLEN-1:0] eval);
        ent_t e;
        rst            = r;
        bus.load_valid = lv;
        bus.load_rd    = lrd;
        bus.load_value = lval;
        bus.exec_valid = ev;
        bus.exec_rd    = erd;
        bus.exec_value = eval;
        if (r) begin
            q.delete();
            exp_we   = 1'b0;
            exp_addr = '0;
            exp_data = '0;
        end else begin
            if (q.size() < DEPTH-1) begin
                if (lv && lrd != '0) q.push_back('{rd: lrd, val: lval});
                if (ev && erd != '0) q.push_back('{rd: erd, val: eval});
            end
            if (q.size() > 0) begin
                e        = q.pop_front();
                exp_we   = 1'b1;
                exp_addr = e.rd;
                exp_data = e.val;
            end else begin
                exp_we = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_eq("rf_we",     64'(bus.rf_we),    64'(exp_we));
        check_eq("rf_waddr",  64'(bus.rf_waddr), 64'(exp_addr));
        check_eq("rf_wdata",  64'(bus.rf_wdata), 64'(exp_data));
        check_eq("occupancy", 64'(occupancy),    64'(q.size()));
        check_eq("stall_o",   64'(bus.stall_o),  64'(q.size() >= DEPTH-1));
`ifdef WB_BUF_FWD_EN
        fwd_probe(RA_W'($urandom_range(0, 7)));
`endif
        $display("cyc %0d rst=%0b ld=%0b/%0d ex=%0b/%0d -> we=%0b %0d/%0h occ=%0d stall=%0b",
                 cyc, r, lv, lrd, ev, erd, bus.rf_we, bus.rf_waddr, bus.rf_wdata,
                 occupancy, bus.stall_o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_rd    = '0;
        bus.load_value = '0;
        bus.exec_valid = 1'b0;
        bus.exec_rd    = '0;
        bus.exec_value = '0;
`ifdef WB_BUF_FWD_EN
        fwd_rs = '0;
`endif
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        @(negedge clk);

        // Reset held with a valid load offered: nothing written until reset drops
        step(1'b1, 1'b1, 5'd5, 32'h55, 1'b0, '0, '0);
        step(1'b1, 1'b1, 5'd5, 32'h55, 1'b0, '0, '0);
        step(1'b0, 1'b1, 5'd5, 32'h55, 1'b0, '0, '0);
        idle(1);

        // Single exec result on an empty buffer
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 32'h11);
        idle(1);

        // Same rd on load and exec: load then exec
        step(1'b0, 1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB);
        idle(2);

        // Fill to the stall threshold, offer a pair while stalled, then drain
        step(1'b0, 1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h102);
        step(1'b0, 1'b1, 5'd3, 32'h103, 1'b1, 5'd4, 32'h104);
        step(1'b0, 1'b1, 5'd5, 32'h105, 1'b1, 5'd6, 32'h106);
        check_eq("stall_at_full", 64'(bus.stall_o), 64'(1));
        step(1'b0, 1'b1, 5'd10, 32'hDEAD, 1'b1, 5'd11, 32'hBEEF);
        idle(5);

        // rd==0 load dropped, exec written
        step(1'b0, 1'b1, 5'd0, 32'h77, 1'b1, 5'd9, 32'h5);
        idle(1);

`ifdef WB_BUF_FWD_EN
        // Two buffered writes to rd=4: the younger one is forwarded
        step(1'b0, 1'b1, 5'd10, 32'h10, 1'b1, 5'd11, 32'h11);
        step(1'b0, 1'b1, 5'd4, 32'h1, 1'b1, 5'd4, 32'h2);
        fwd_probe(5'd4);
        check_eq("fwd_rs4_hit", 64'(fwd_hit), 64'(1));
        check_eq("fwd_rs4_val", 64'(fwd_value), 64'(32'h2));
        fwd_probe(5'd0);
        check_eq("fwd_rs0_hit", 64'(fwd_hit), 64'(0));
        idle(4);
`endif

        // Randomized traffic with occasional mid-operation reset
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) < 6, RA_W'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 9) < 6, RA_W'($urandom_range(0, 7)), $urandom);
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
